// File: rtl/uart_alu_sequencer.sv
// Turns three received bytes into an ALU command (A, B, opcode), then hands the result to the transmitter.
// Optional inter-byte timeout is enabled by defining RX_TIMEOUT_EN.
module uart_alu_sequencer #(
    parameter int NDATA_BITS     = 8,
    parameter int NOP_BITS       = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NDATA_BITS-1:0] i_rx_data,
    input  logic                  i_rx_done,
    input  logic [NDATA_BITS-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [NDATA_BITS-1:0] o_alu_a,
    output logic [NDATA_BITS-1:0] o_alu_b,
    output logic [NOP_BITS-1:0]   o_alu_op,
    output logic [NDATA_BITS-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic                  o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t state, state_nxt;

    logic rx_done_q, tx_done_q;
    logic rx_stb, tx_stb;
    logic load_a, load_b, load_op, load_tx;
    logic start_nxt, overrun_nxt;
    logic timeout_hit;

    // Done flags are levels; only the rising edge counts as one event.
    assign rx_stb = i_rx_done & ~rx_done_q;
    assign tx_stb = i_tx_done & ~tx_done_q;

    assign o_busy = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

`ifdef RX_TIMEOUT_EN
    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TCNT_W-1:0] tcnt;
    logic              tcnt_run;

    assign tcnt_run    = (state == WAIT_B) || (state == WAIT_OP);
    assign timeout_hit = tcnt_run && !rx_stb && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tcnt      <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
            if (!tcnt_run || rx_stb || (state_nxt != state))
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_op     = 1'b0;
        load_tx     = 1'b0;
        start_nxt   = 1'b0;
        overrun_nxt = rx_stb && o_busy;
        case (state)
            WAIT_A: begin
                if (rx_stb) begin
                    load_a    = 1'b1;
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_stb) begin
                    load_b    = 1'b1;
                    state_nxt = WAIT_OP;
                end else if (timeout_hit) begin
                    state_nxt = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (rx_stb) begin
                    load_op   = 1'b1;
                    state_nxt = EXEC;
                end else if (timeout_hit) begin
                    state_nxt = WAIT_A;
                end
            end
            EXEC: begin
                // Operands have been stable for a full cycle; ALU output is settled.
                load_tx   = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                start_nxt = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_stb)
                    state_nxt = WAIT_A;
            end
            default: state_nxt = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_done_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            rx_done_q  <= i_rx_done;
            tx_done_q  <= i_tx_done;
            o_tx_start <= start_nxt;
            o_overrun  <= overrun_nxt;
            if (load_a)  o_alu_a   <= i_rx_data;
            if (load_b)  o_alu_b   <= i_rx_data;
            if (load_op) o_alu_op  <= i_rx_data[NOP_BITS-1:0];
            if (load_tx) o_tx_data <= i_alu_result;
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: vector table, multi-cycle corner sequences, random commands.
module tb_uart_alu_sequencer;

    localparam int NB  = 8;
    localparam int NOP = 6;
`ifdef RX_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 1000000;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [NB-1:0]  rx_data;
    logic           rx_done;
    logic           tx_done;
    logic [NB-1:0]  alu_result;
    logic [NB-1:0]  alu_a, alu_b, tx_data;
    logic [NOP-1:0] alu_op;
    logic           tx_start, busy, overrun, timeout;

    int total = 0;
    int pass  = 0;
    int n_start = 0, n_ovr = 0, n_tmo = 0;

    always #5 clk = ~clk;

    uart_alu_sequencer #(
        .NDATA_BITS    (NB),
        .NOP_BITS      (NOP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_alu_result(alu_result),
        .i_tx_done   (tx_done),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_busy      (busy),
        .o_overrun   (overrun),
        .o_timeout   (timeout)
    );

    // Combinational ALU standing in for the real one (MIPS-style function codes).
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    // Pulse counters sample shortly after the edge, away from the update.
    always @(posedge clk) begin
        #2;
        if (tx_start) n_start++;
        if (overrun)  n_ovr++;
        if (timeout)  n_tmo++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        rx_data = d;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic tx_ack();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Called right after the opcode byte: start must appear in the 3rd cycle after that edge.
    task automatic expect_result(input string nm, input logic [7:0] a, input logic [7:0] b,
                                 input logic [5:0] op, input logic [7:0] res);
        int cyc = 1;
        while (!tx_start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_latency"}, cyc, 3);
        check({nm, "_a"}, alu_a, a);
        check({nm, "_b"}, alu_b, b);
        check({nm, "_op"}, alu_op, op);
        check({nm, "_tx_data"}, tx_data, res);
        check({nm, "_busy"}, busy, 1);
        @(negedge clk);
        check({nm, "_start_one_cycle"}, tx_start, 0);
    endtask

    task automatic run_cmd(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] opb, input logic [5:0] op, input logic [7:0] res);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
        expect_result(nm, a, b, op, res);
        tx_ack();
        check({nm, "_idle_after_tx"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] op;
        logic [7:0] res;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int s0, o0, t0, strays;
        logic [5:0] ops[6];
        logic [7:0] ra, rb, rop;
        logic [5:0] rop6;

        tbl[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
        tbl[1] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
        tbl[2] = '{8'h10, 8'h10, 8'h22, 6'h22, 8'h00};
        tbl[3] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
        tbl[4] = '{8'hF0, 8'h3C, 8'h25, 6'h25, 8'hFC};
        tbl[5] = '{8'h0F, 8'hFF, 8'h26, 6'h26, 8'hF0};
        tbl[6] = '{8'hAA, 8'h55, 8'hE6, 6'h26, 8'hFF};
        tbl[7] = '{8'h80, 8'h01, 8'hA2, 6'h22, 8'h7F};
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};

        rst = 1'b1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        rx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_operands", {alu_a, alu_b, alu_op, tx_data}, 0);
        check("reset_flags", {tx_start, busy, overrun, timeout}, 0);
        rst = 1'b0;

        // Table vectors, run back to back; each must give exactly one start pulse.
        s0 = n_start;
        for (int i = 0; i < 8; i++)
            run_cmd($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].opb, tbl[i].op, tbl[i].res);
        check("vec_start_pulses", n_start - s0, 8);

        // Receiver done held high for 40 cycles is a single byte.
        s0 = n_start;
        @(negedge clk);
        rx_data = 8'hAA;
        rx_done = 1'b1;
        repeat (40) @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
        check("level_a_loaded", alu_a, 8'hAA);
        check("level_b_kept", alu_b, 8'h01);
        check("level_no_start", n_start - s0, 0);
        check("level_not_busy", busy, 0);
        tx_ack();  // stray transmitter done outside WAIT_TX is ignored
        send_byte(8'h01);
        send_byte(8'h20);
        expect_result("level_cmd", 8'hAA, 8'h01, 6'h20, 8'hAB);
        tx_ack();

        // Byte during WAIT_TX is dropped with one overrun pulse.
        send_byte(8'h21);
        send_byte(8'h02);
        send_byte(8'h22);
        expect_result("ovr_cmd", 8'h21, 8'h02, 6'h22, 8'h1F);
        o0 = n_ovr;
        send_byte(8'h77);
        @(negedge clk);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_a_kept", alu_a, 8'h21);
        check("ovr_still_busy", busy, 1);
        tx_ack();
        check("ovr_idle", busy, 0);
        run_cmd("after_ovr", 8'h30, 8'h0C, 8'h25, 6'h25, 8'h3C);

        // Receive and transmit done in the same cycle while in WAIT_TX.
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h20);
        expect_result("both_cmd", 8'h03, 8'h04, 6'h20, 8'h07);
        o0 = n_ovr;
        @(negedge clk);
        rx_data = 8'h99;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        check("both_ovr_pulse", n_ovr - o0, 1);
        check("both_idle", busy, 0);
        check("both_a_kept", alu_a, 8'h03);
        run_cmd("after_both", 8'h50, 8'h05, 8'h22, 6'h22, 8'h4B);

        // Asynchronous reset in WAIT_OP.
        send_byte(8'h12);
        send_byte(8'h34);
        check("pre_reset_a", alu_a, 8'h12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_operands", {alu_a, alu_b, alu_op, tx_data}, 0);
        check("async_reset_flags", {tx_start, busy, overrun, timeout}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_cmd("post_reset", 8'h12, 8'h34, 8'h20, 6'h20, 8'h46);

        // Partial command followed by a long idle period.
        t0 = n_tmo;
        send_byte(8'h11);
`ifdef RX_TIMEOUT_EN
        repeat (99) @(negedge clk);
        check("timeout_not_early", n_tmo - t0, 0);
        @(negedge clk);
        check("timeout_pulse", n_tmo - t0, 1);
        repeat (3) @(negedge clk);
        check("timeout_single", n_tmo - t0, 1);
        run_cmd("after_timeout", 8'h40, 8'h02, 8'h20, 6'h20, 8'h42);
`else
        repeat (150) @(negedge clk);
        check("no_timeout", n_tmo - t0, 0);
        check("wait_a_kept", alu_a, 8'h11);
        send_byte(8'h22);
        send_byte(8'h20);
        expect_result("late_cmd", 8'h11, 8'h22, 6'h20, 8'h33);
        tx_ack();
`endif

        // Random commands with gaps and stray bytes while busy.
        s0 = n_start;
        o0 = n_ovr;
        strays = 0;
        for (int i = 0; i < 25; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rop6 = ops[$urandom_range(0, 5)];
            rop  = {2'($urandom), rop6};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(ra);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(rb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(rop);
            expect_result($sformatf("rnd%0d", i), ra, rb, rop6, alu_f(ra, rb, rop6));
            if ($urandom_range(0, 2) == 0) begin
                send_byte(8'($urandom));
                strays++;
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            tx_ack();
        end
        @(negedge clk);
        check("rnd_start_pulses", n_start - s0, 25);
        check("rnd_overruns", n_ovr - o0, strays);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
